// File: rtl/pipe_defs_pkg.sv
// Shared pipeline definitions: opcode/funct codes, the nop encoding and
// the IF/ID stage FSM state type.
package pipe_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_BUBBLE = 2'd2
  } stage_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the instruction sitting in IF/ID.
// Decodes which source registers the instruction reads and compares them
// against the destinations of the loads/ALU ops still in EX and MEM.
module hazard_detect
  import pipe_defs::*;
#(
  parameter int REG_W = 5
) (
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             valid,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_reg_write,
  input  logic [REG_W-1:0] id_ex_write_reg,
  input  logic             ex_mem_mem_read,
  input  logic [REG_W-1:0] ex_mem_write_reg,
  output logic             hazard
);

  logic is_jr;
  logic is_branch;
  logic uses_rt;
  logic ex_match;
  logic mem_match;

  // A producer register matches when it is non-zero and equals a source the
  // instruction actually reads ($zero is hardwired and never forwards).
  function automatic logic src_match(input logic [REG_W-1:0] wr,
                                     input logic [REG_W-1:0] rs_f,
                                     input logic [REG_W-1:0] rt_f,
                                     input logic             use_rt);
    return (wr != '0) && ((wr == rs_f) || (use_rt && (wr == rt_f)));
  endfunction

  // Source-use decode and the three stall rules (load-use, ALU->branch,
  // load->branch second stall); a flushed bubble never stalls.
  always_comb begin
    is_jr     = (op == OP_RTYPE) && (funct == FN_JR);
    is_branch = (op == OP_BEQ) || (op == OP_BNE) || is_jr;
    uses_rt   = ((op == OP_RTYPE) && !is_jr) || (op == OP_BEQ) ||
                (op == OP_BNE) || (op == OP_SW);
    ex_match  = src_match(id_ex_write_reg, rs, rt, uses_rt);
    mem_match = src_match(ex_mem_write_reg, rs, rt, uses_rt);
    hazard    = valid && ((id_ex_mem_read && ex_match) ||
                          (is_branch && id_ex_reg_write && ex_match) ||
                          (is_branch && ex_mem_mem_read && mem_match));
  end

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with hazard-driven stall and branch flush.
// Holds the fetched instruction and PC+4 on a hazard, replaces them with a
// nop bubble on a taken branch, and tells fetch whether to advance the PC.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
module if_id_hazard_stage
  import pipe_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] FetchInstr,
  input  logic [DATA_W-1:0] FetchPC,
  input  logic              IdExMemRead,
  input  logic              IdExRegWrite,
  input  logic [REG_W-1:0]  IdExWriteReg,
  input  logic              ExMemMemRead,
  input  logic [REG_W-1:0]  ExMemWriteReg,
  input  logic              BranchTaken,
  output logic [DATA_W-1:0] IfIdInstr,
  output logic [DATA_W-1:0] IfIdPCPlus4,
  output logic              IfIdValid,
  output logic              StallMuxSelector,
  output logic              CtrlBubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
`endif
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  stage_state_e      state_q, state_d;
  logic              hazard;
  logic              flush;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .op              (instr_q[31:26]),
    .funct           (instr_q[5:0]),
    .rs              (REG_W'(instr_q[25:21])),
    .rt              (REG_W'(instr_q[20:16])),
    .valid           (valid_q),
    .id_ex_mem_read  (IdExMemRead),
    .id_ex_reg_write (IdExRegWrite),
    .id_ex_write_reg (IdExWriteReg),
    .ex_mem_mem_read (ExMemMemRead),
    .ex_mem_write_reg(ExMemWriteReg),
    .hazard          (hazard)
  );

  // A stall outranks a branch: the branch operands are not ready yet, so
  // its outcome this cycle cannot be trusted.
  assign flush            = BranchTaken && !hazard;
  assign StallMuxSelector = !hazard;
  assign CtrlBubble       = hazard || (state_q == ST_BUBBLE);
  assign IfIdInstr        = instr_q;
  assign IfIdPCPlus4      = pc4_q;
  assign IfIdValid        = valid_q;

  // Next-state and register update; every state follows the same
  // hazard > flush > load priority (BUBBLE never sees a hazard because the
  // flushed entry is invalid).
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (hazard) begin
      state_d = ST_STALL;
    end else if (flush) begin
      state_d = ST_BUBBLE;
      instr_d = DATA_W'(NOP);
      pc4_d   = '0;
      valid_d = 1'b0;
    end else begin
      state_d = ST_RUN;
      instr_d = FetchInstr;
      pc4_d   = FetchPC + DATA_W'(4);
      valid_d = 1'b1;
    end
  end

  // Pipeline register and FSM state, cleared by synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_RUN;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: stop at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Counter registers, cleared by synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Scoreboard bench for if_id_hazard_stage: the driver pushes the expected
// response of every cycle it drives, the monitor pops and compares it.
module tb_if_id_hazard_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [DATA_W-1:0] FetchInstr;
  logic [DATA_W-1:0] FetchPC;
  logic              IdExMemRead;
  logic              IdExRegWrite;
  logic [REG_W-1:0]  IdExWriteReg;
  logic              ExMemMemRead;
  logic [REG_W-1:0]  ExMemWriteReg;
  logic              BranchTaken;
  logic [DATA_W-1:0] IfIdInstr;
  logic [DATA_W-1:0] IfIdPCPlus4;
  logic              IfIdValid;
  logic              StallMuxSelector;
  logic              CtrlBubble;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;
`endif

  typedef struct {
    string       name;
    bit          chkComb;
    logic        expSel;
    logic        expBub;
    logic [31:0] expInstr;
    logic [31:0] expPc4;
    logic        expValid;
    int          expStall;
    int          expFlush;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Free-running clock, period 10.
  always #5 Clk = ~Clk;

  if_id_hazard_stage dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .FetchInstr      (FetchInstr),
    .FetchPC         (FetchPC),
    .IdExMemRead     (IdExMemRead),
    .IdExRegWrite    (IdExRegWrite),
    .IdExWriteReg    (IdExWriteReg),
    .ExMemMemRead    (ExMemMemRead),
    .ExMemWriteReg   (ExMemWriteReg),
    .BranchTaken     (BranchTaken),
    .IfIdInstr       (IfIdInstr),
    .IfIdPCPlus4     (IfIdPCPlus4),
    .IfIdValid       (IfIdValid),
    .StallMuxSelector(StallMuxSelector),
    .CtrlBubble      (CtrlBubble)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount      (StallCount),
    .FlushCount      (FlushCount)
`endif
  );

  function automatic logic [31:0] rType(input int rs, input int rt, input int rd, input int fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, 6'(fn)};
  endfunction

  function automatic logic [31:0] iType(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the DUT
  // must show: combinational outputs during this cycle, registers after it.
  task automatic applyStimulus(input string name, input bit rstN,
                               input logic [31:0] fInstr, input logic [31:0] fPc,
                               input bit exRd, input bit exWr, input int exReg,
                               input bit memRd, input int memReg, input bit br,
                               input bit chkComb, input bit eSel, input bit eBub,
                               input logic [31:0] eInstr, input logic [31:0] ePc4,
                               input bit eValid, input int eStall, input int eFlush);
    exp_t e;
    @(negedge Clk);
    Rst_n         = rstN;
    FetchInstr    = fInstr;
    FetchPC       = fPc;
    IdExMemRead   = exRd;
    IdExRegWrite  = exWr;
    IdExWriteReg  = REG_W'(exReg);
    ExMemMemRead  = memRd;
    ExMemWriteReg = REG_W'(memReg);
    BranchTaken   = br;
    e.name     = name;
    e.chkComb  = chkComb;
    e.expSel   = eSel;
    e.expBub   = eBub;
    e.expInstr = eInstr;
    e.expPc4   = ePc4;
    e.expValid = eValid;
    e.expStall = eStall;
    e.expFlush = eFlush;
    sb.push_back(e);
  endtask

  // Monitor: sample comb outputs mid-cycle, registers just after the edge,
  // then retire the matching scoreboard entry.
  initial begin
    exp_t e;
    logic aSel;
    logic aBub;
    forever begin
      @(negedge Clk);
      #2;
      aSel = StallMuxSelector;
      aBub = CtrlBubble;
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chkComb) begin
          checkOutput(e.name, "StallMuxSelector", 32'(aSel), 32'(e.expSel));
          checkOutput(e.name, "CtrlBubble", 32'(aBub), 32'(e.expBub));
        end
        checkOutput(e.name, "IfIdInstr", IfIdInstr, e.expInstr);
        checkOutput(e.name, "IfIdPCPlus4", IfIdPCPlus4, e.expPc4);
        checkOutput(e.name, "IfIdValid", 32'(IfIdValid), 32'(e.expValid));
`ifdef HAZARD_STATS_EN
        checkOutput(e.name, "StallCount", 32'(StallCount), 32'(e.expStall));
        checkOutput(e.name, "FlushCount", 32'(FlushCount), 32'(e.expFlush));
`endif
      end
    end
  end

  // Run-time bound in case the stimulus never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed stimulus; arguments after br are: chkComb, sel, bubble,
  // instr, pc+4, valid, stallCount, flushCount.
  initial begin
    logic [31:0] a0, a1, a2, addT1, x1, beqI, yI, tI, zI, wI, swI, jrI, lwI;
    a0    = rType(2, 3, 1, 32);
    a1    = rType(5, 6, 4, 32);
    a2    = rType(8, 9, 7, 32);
    addT1 = rType(9, 19, 10, 32);
    x1    = rType(12, 13, 11, 32);
    beqI  = iType(4, 9, 10, 16);
    yI    = rType(15, 16, 14, 32);
    tI    = rType(0, 18, 17, 32);
    zI    = rType(21, 22, 20, 32);
    wI    = rType(24, 25, 23, 32);
    swI   = iType(43, 6, 5, 0);
    jrI   = rType(31, 0, 0, 8);
    lwI   = iType(35, 9, 8, 0);

    Rst_n = 1'b0; FetchInstr = '0; FetchPC = '0; IdExMemRead = 1'b0;
    IdExRegWrite = 1'b0; IdExWriteReg = '0; ExMemMemRead = 1'b0;
    ExMemWriteReg = '0; BranchTaken = 1'b0;

    applyStimulus("reset1", 0, 32'hDEADBEEF, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus("reset2", 0, 32'hDEADBEEF, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus("flow0", 1, a0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, a0, 32'h4, 1, 0, 0);
    applyStimulus("flow1", 1, a1, 32'h4, 0, 0, 0, 0, 0, 0, 1, 1, 0, a1, 32'h8, 1, 0, 0);
    applyStimulus("flow2", 1, a2, 32'h8, 0, 0, 0, 0, 0, 0, 1, 1, 0, a2, 32'hC, 1, 0, 0);
    applyStimulus("ldUseFetch", 1, addT1, 32'h20, 0, 0, 0, 0, 0, 0, 1, 1, 0, addT1, 32'h24, 1, 0, 0);
    applyStimulus("ldUseStall", 1, x1, 32'h24, 1, 0, 9, 0, 0, 0, 1, 0, 1, addT1, 32'h24, 1, 1, 0);
    applyStimulus("ldUseResume", 1, x1, 32'h24, 0, 0, 0, 1, 9, 0, 1, 1, 0, x1, 32'h28, 1, 1, 0);
    applyStimulus("brFetch", 1, beqI, 32'h30, 0, 0, 0, 0, 0, 0, 1, 1, 0, beqI, 32'h34, 1, 1, 0);
    applyStimulus("brStallEx", 1, yI, 32'h34, 1, 1, 9, 0, 0, 0, 1, 0, 1, beqI, 32'h34, 1, 2, 0);
    applyStimulus("brStallMem", 1, yI, 32'h34, 0, 0, 0, 1, 9, 1, 1, 0, 1, beqI, 32'h34, 1, 3, 0);
    applyStimulus("brFlush", 1, yI, 32'h34, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h0, 32'h0, 0, 3, 1);
    applyStimulus("brTarget", 1, tI, 32'h80, 0, 0, 0, 0, 0, 0, 1, 1, 1, tI, 32'h84, 1, 3, 1);
    applyStimulus("zeroDest", 1, zI, 32'h84, 1, 1, 0, 0, 0, 0, 1, 1, 0, zI, 32'h88, 1, 3, 1);
    applyStimulus("runFlush", 1, wI, 32'h88, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h0, 32'h0, 0, 3, 2);
    applyStimulus("swFetch", 1, swI, 32'h90, 0, 0, 0, 0, 0, 0, 1, 1, 1, swI, 32'h94, 1, 3, 2);
    applyStimulus("swRtStall", 1, a0, 32'h94, 1, 0, 5, 0, 0, 0, 1, 0, 1, swI, 32'h94, 1, 4, 2);
    applyStimulus("rstInStall", 0, a0, 32'h94, 1, 0, 5, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus("pcWrap", 1, jrI, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 1, 1, 0, jrI, 32'h0, 1, 0, 0);
    applyStimulus("jrAluStall", 1, lwI, 32'h200, 0, 1, 31, 0, 0, 0, 1, 0, 1, jrI, 32'h0, 1, 1, 0);
    applyStimulus("jrResume", 1, lwI, 32'h200, 0, 0, 0, 0, 0, 0, 1, 1, 0, lwI, 32'h204, 1, 1, 0);
    applyStimulus("lwNoRt", 1, a0, 32'h204, 1, 0, 8, 0, 0, 0, 1, 1, 0, a0, 32'h208, 1, 1, 0);

    repeat (3) @(negedge Clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboardDrain actual=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
